regs_sb: RTL and testbench
==========================

// Module: regs_sb
// PURPOSE
//   Parametrised picoMIPS register file: 2**R_SIZE x n registers, %0 reads as zero, 2 async read ports, 1 sync write port.
//   Adds a per-register pending scoreboard so multi-cycle units (multiplier, loads) raise hazards until writeback.
//   Optional write-to-read bypass. Sits between decode (Raddr/issue) and writeback (we/Waddr/Wdata).
// PARAMETERS
//   n       8  data width in bits
//   R_SIZE  2  register address width; depth = 2**R_SIZE
//   BYPASS  1  1: read port returns same-cycle Wdata on address match; 0: reads see committed value only
// PORTS
//   clk      input   1       clock; all state updates on posedge
//   n_reset  input   1       synchronous reset, active-low
//   we       input   1       write enable
//   Waddr    input   R_SIZE  write address
//   Wdata    input   n       write data
//   Raddr1   input   R_SIZE  read address, port 1
//   Raddr2   input   R_SIZE  read address, port 2
//   Rdata1   output  n       read data, port 1 (combinational)
//   Rdata2   output  n       read data, port 2 (combinational)
//   issue    input   1       mark Iaddr pending (multi-cycle producer dispatched)
//   Iaddr    input   R_SIZE  destination register of issued producer
//   busy1    output  1       Raddr1 operand not yet produced
//   busy2    output  1       Raddr2 operand not yet produced
//   stall    output  1       busy1 | busy2
// BEHAVIOUR
//   Reset: posedge with n_reset==0 -> every register := 0, every pend bit := 0.
//     Reset dominates we and issue. Reset mid-operation discards in-flight writes and pending state.
//   Write: posedge, n_reset==1, we==1, Waddr!=0 -> regs[Waddr] := Wdata. Waddr==0 is a silent no-op.
//   Read: RdataK = (RaddrK==0) ? 0 : regs[RaddrK]; zero latency.
//     With BYPASS=1: we && Waddr==RaddrK && RaddrK!=0 -> RdataK = Wdata in the same cycle.
//     Both ports may address the same register; both return identical data.
//   Scoreboard pend[2**R_SIZE-1:1] (pend[0] is constant 0):
//     Set: issue && Iaddr!=0 -> pend[Iaddr] := 1 at next posedge.
//     Clear: we && Waddr!=0 -> pend[Waddr] := 0 at next posedge.
//     Same register set and cleared in one cycle -> set wins; the new producer supersedes the old one.
//     Issue to an already-pending register keeps it at 1 (WAW). The next write clears it.
//     The block does not count outstanding producers.
//   busyK = pend[RaddrK] && !(BYPASS && we && Waddr==RaddrK). RaddrK==0 -> busyK=0.
//   stall = busy1 | busy2; purely combinational, no registered outputs.
//   After reset: Rdata1=Rdata2=0, busy1=busy2=stall=0.
//   Width: Wdata stored unmodified. No sign extension or truncation inside the block.
// STRUCTURE
//   Package pmips_pkg holds the shared definitions:
//     typedef logic [R_SIZE-1:0] reg_addr_t; localparam ZERO_REG = '0.
//     Width constants shared with decode and the ALU.
//   Sub-module pmips_scoreboard (clk, n_reset, issue, Iaddr, we, Waddr, Raddr1, Raddr2 -> busy1, busy2).
//     The register array and read muxes stay in regs_sb.
// TESTING  (n=8, R_SIZE=2, BYPASS=1 unless noted)
//   1. n_reset=0 for 1 edge after random writes -> Rdata1=Rdata2=0 for all addresses; busy1=busy2=0.
//   2. Write 8'd7 to %1, 8'd6 to %2, 8'd5 to %3 -> reads of 1/2/3 give 7/6/5.
//      Write 8'hFF to %0 -> %0 still reads 0.
//   3. Bypass: we=1, Waddr=2, Wdata=8'd3, Raddr1=2 -> Rdata1=3 in the same cycle.
//      Repeat with BYPASS=0 -> old value until the following cycle.
//   4. issue Iaddr=3; next cycle Raddr2=3 -> busy2=1, stall=1.
//      we Waddr=3 Wdata=8'd4 -> busy2=0 same cycle (bypass), pend[3]=0 after edge, Rdata2=4.
//   5. Same cycle: issue Iaddr=1 and we Waddr=1 -> after edge pend[1]=1 and regs[1]=Wdata.
//      issue Iaddr=0 -> busy never asserted for %0.
//   6. issue Iaddr=2, then assert n_reset=0 with we=1 Waddr=2 -> after edge pend[2]=0 and regs[2]=0.

Source files
------------

// File: rtl/pmips_pkg.sv
// Shared picoMIPS definitions: default widths and the
// register-address type used by decode, ALU and register file.
package pmips_pkg;
  localparam int DATA_W = 8;
  localparam int RADDR_W = 2;
  typedef logic [RADDR_W-1:0] reg_addr_t;
  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/pmips_scoreboard.sv
// Per-register pending bits for multi-cycle producers; a
// register is busy from issue until its writeback lands.
module pmips_scoreboard
  import pmips_pkg::*;
#(
  parameter int R_SIZE = RADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              issue,
  input  logic [R_SIZE-1:0] Iaddr,
  input  logic              we,
  input  logic [R_SIZE-1:0] Waddr,
  input  logic [R_SIZE-1:0] Raddr1,
  input  logic [R_SIZE-1:0] Raddr2,
  output logic              busy1,
  output logic              busy2
);
  localparam int DEPTH = 2 ** R_SIZE;

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic             byp1;
  logic             byp2;

  // Clear first so a same-cycle issue re-arms the bit.
  always_comb begin
    pend_d = pend_q;
    if (we && Waddr != '0)
      pend_d[Waddr] = 1'b0;
    if (issue && Iaddr != '0)
      pend_d[Iaddr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!n_reset)
      pend_q <= '0;
    else
      pend_q <= pend_d;
  end

  always_comb begin
    byp1  = (BYPASS != 0) && we && (Waddr == Raddr1);
    byp2  = (BYPASS != 0) && we && (Waddr == Raddr2);
    busy1 = pend_q[Raddr1] && !byp1;
    busy2 = pend_q[Raddr2] && !byp2;
  end
endmodule

// File: rtl/regs_sb.sv
// picoMIPS register file: %0 hardwired to zero, two async
// read ports, one sync write port, pending scoreboard.
module regs_sb
  import pmips_pkg::*;
#(
  parameter int n      = DATA_W,
  parameter int R_SIZE = RADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              we,
  input  logic [R_SIZE-1:0] Waddr,
  input  logic [n-1:0]      Wdata,
  input  logic [R_SIZE-1:0] Raddr1,
  input  logic [R_SIZE-1:0] Raddr2,
  output logic [n-1:0]      Rdata1,
  output logic [n-1:0]      Rdata2,
  input  logic              issue,
  input  logic [R_SIZE-1:0] Iaddr,
  output logic              busy1,
  output logic              busy2,
  output logic              stall
);
  localparam int DEPTH = 2 ** R_SIZE;

  logic [n-1:0] regs_q [DEPTH];
  logic [n-1:0] regs_d [DEPTH];

  always_comb begin
    regs_d = regs_q;
    if (we && Waddr != '0)
      regs_d[Waddr] = Wdata;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    Rdata1 = regs_q[Raddr1];
    Rdata2 = regs_q[Raddr2];
    if ((BYPASS != 0) && we && Waddr == Raddr1)
      Rdata1 = Wdata;
    if ((BYPASS != 0) && we && Waddr == Raddr2)
      Rdata2 = Wdata;
    if (Raddr1 == '0)
      Rdata1 = '0;
    if (Raddr2 == '0)
      Rdata2 = '0;
  end

  pmips_scoreboard #(
    .R_SIZE (R_SIZE),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk     (clk),
    .n_reset (n_reset),
    .issue   (issue),
    .Iaddr   (Iaddr),
    .we      (we),
    .Waddr   (Waddr),
    .Raddr1  (Raddr1),
    .Raddr2  (Raddr2),
    .busy1   (busy1),
    .busy2   (busy2)
  );

  assign stall = busy1 | busy2;
endmodule

// File: tb/tb_regs_sb.sv
// Bench for regs_sb: BYPASS=1 and BYPASS=0 copies share inputs
// and are checked every cycle against a behavioural model.
module tb_regs_sb;
  logic       clk = 0;
  logic       n_reset, we, issue;
  logic [1:0] Waddr, Raddr1, Raddr2, Iaddr;
  logic [7:0] Wdata;
  logic [7:0] rd1_u, rd2_u, rd1_b, rd2_b;
  logic       b1_u, b2_u, st_u, b1_b, b2_b, st_b;

  int errors = 0;
  int checks = 0;
  bit armed = 0;

  int mreg [4];
  bit mpend [4];

  always #5 clk = ~clk;

  regs_sb #(.n(8), .R_SIZE(2), .BYPASS(1)) u_dut (
    .clk(clk), .n_reset(n_reset), .we(we), .Waddr(Waddr),
    .Wdata(Wdata), .Raddr1(Raddr1), .Raddr2(Raddr2),
    .Rdata1(rd1_u), .Rdata2(rd2_u), .issue(issue),
    .Iaddr(Iaddr), .busy1(b1_u), .busy2(b2_u), .stall(st_u)
  );

  regs_sb #(.n(8), .R_SIZE(2), .BYPASS(0)) b_dut (
    .clk(clk), .n_reset(n_reset), .we(we), .Waddr(Waddr),
    .Wdata(Wdata), .Raddr1(Raddr1), .Raddr2(Raddr2),
    .Rdata1(rd1_b), .Rdata2(rd2_b), .issue(issue),
    .Iaddr(Iaddr), .busy1(b1_b), .busy2(b2_b), .stall(st_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_rd(input int a, input bit byp);
    if (a == 0) return 0;
    if (byp && we && int'(Waddr) == a) return int'(Wdata);
    return mreg[a];
  endfunction

  function automatic bit m_busy(input int a, input bit byp);
    if (a == 0) return 0;
    return mpend[a] && !(byp && we && int'(Waddr) == a);
  endfunction

  always @(posedge clk) begin
    if (!n_reset) begin
      for (int i = 0; i < 4; i++) begin
        mreg[i] = 0;
        mpend[i] = 0;
      end
    end else begin
      if (we && Waddr != 0) begin
        mreg[Waddr] = Wdata;
        mpend[Waddr] = 0;
      end
      if (issue && Iaddr != 0) mpend[Iaddr] = 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m_rd1_u", rd1_u, m_rd(Raddr1, 1));
      chk("m_rd2_u", rd2_u, m_rd(Raddr2, 1));
      chk("m_rd1_b", rd1_b, m_rd(Raddr1, 0));
      chk("m_rd2_b", rd2_b, m_rd(Raddr2, 0));
      chk("m_busy1_u", b1_u, m_busy(Raddr1, 1));
      chk("m_busy2_u", b2_u, m_busy(Raddr2, 1));
      chk("m_busy1_b", b1_b, m_busy(Raddr1, 0));
      chk("m_busy2_b", b2_b, m_busy(Raddr2, 0));
      chk("m_stall_u", st_u, m_busy(Raddr1, 1) | m_busy(Raddr2, 1));
      chk("m_stall_b", st_b, m_busy(Raddr1, 0) | m_busy(Raddr2, 0));
    end
  end

  task automatic drv(input logic rn, input logic w, input logic [1:0] wa,
                     input logic [7:0] wd, input logic [1:0] r1,
                     input logic [1:0] r2, input logic is,
                     input logic [1:0] ia);
    @(posedge clk);
    #1;
    n_reset = rn; we = w; Waddr = wa; Wdata = wd;
    Raddr1 = r1; Raddr2 = r2; issue = is; Iaddr = ia;
  endtask

  initial begin
    n_reset = 0; we = 0; Waddr = 0; Wdata = 0;
    Raddr1 = 0; Raddr2 = 0; issue = 0; Iaddr = 0;
    @(posedge clk);
    #1;
    armed = 1;
    // 1: random writes and issues, then a one-edge reset
    for (int i = 0; i < 6; i++)
      drv(1, 1, 2'($urandom_range(0, 3)), 8'($urandom),
          0, 0, 1, 2'($urandom_range(0, 3)));
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 4; a++) begin
      drv(1, 0, 0, 0, 2'(a), 2'(3 - a), 0, 0);
      @(negedge clk);
      chk("rst_rd1", rd1_u, 0);
      chk("rst_rd2", rd2_u, 0);
      chk("rst_busy", b1_u | b2_u | st_u, 0);
    end
    // 2: plain writes, %0 stays zero
    drv(1, 1, 1, 8'd7, 0, 0, 0, 0);
    drv(1, 1, 2, 8'd6, 0, 0, 0, 0);
    drv(1, 1, 3, 8'd5, 0, 0, 0, 0);
    drv(1, 1, 0, 8'hFF, 1, 2, 0, 0);
    @(negedge clk);
    chk("wr_rd1", rd1_u, 7);
    chk("wr_rd2", rd2_u, 6);
    drv(1, 0, 0, 0, 3, 0, 0, 0);
    @(negedge clk);
    chk("wr_rd3", rd1_u, 5);
    chk("zero_reg", rd2_u, 0);
    // 3: bypass vs committed-only
    drv(1, 1, 2, 8'd3, 2, 1, 0, 0);
    @(negedge clk);
    chk("byp_on", rd1_u, 3);
    chk("byp_off_old", rd1_b, 6);
    drv(1, 0, 0, 0, 2, 1, 0, 0);
    @(negedge clk);
    chk("byp_off_new", rd1_b, 3);
    // 4: issue then writeback
    drv(1, 0, 0, 0, 0, 0, 1, 3);
    drv(1, 0, 0, 0, 0, 3, 0, 0);
    @(negedge clk);
    chk("iss_busy2", b2_u, 1);
    chk("iss_stall", st_u, 1);
    drv(1, 1, 3, 8'd4, 0, 3, 0, 0);
    @(negedge clk);
    chk("wb_busy2_byp", b2_u, 0);
    chk("wb_busy2_nobyp", b2_b, 1);
    drv(1, 0, 0, 0, 0, 3, 0, 0);
    @(negedge clk);
    chk("wb_busy2_after", b2_u, 0);
    chk("wb_rd2", rd2_u, 4);
    // 5: set beats clear; %0 never busy
    drv(1, 1, 1, 8'd9, 0, 0, 1, 1);
    drv(1, 0, 0, 0, 1, 0, 1, 0);
    @(negedge clk);
    chk("setwins_busy", b1_u, 1);
    chk("setwins_rd", rd1_u, 9);
    drv(1, 1, 1, 8'd10, 0, 0, 1, 1);
    drv(1, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("waw_busy", b1_u, 1);
    drv(1, 1, 1, 8'd11, 1, 0, 0, 0);
    drv(1, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("waw_clear", b1_u, 0);
    chk("waw_rd", rd1_u, 11);
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("r0_busy", b1_u | b2_u | st_u, 0);
    // 6: reset dominates write and pending
    drv(1, 0, 0, 0, 0, 0, 1, 2);
    drv(0, 1, 2, 8'd77, 2, 0, 1, 3);
    drv(1, 0, 0, 0, 2, 3, 0, 0);
    @(negedge clk);
    chk("rstdom_busy", b1_u | b2_u, 0);
    chk("rstdom_rd2", rd1_u, 0);
    chk("rstdom_rd3", rd2_u, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    armed = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
